// File: rtl/mwb_pkg.sv
// mwb_pkg: opcode/funct3 constants and load-lane extraction shared by mem_wb_unit.
package mwb_pkg;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        return f3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               f3 == F3_BU ? {24'd0, sh[7:0]} :
               f3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               f3 == F3_HU ? {16'd0, sh[15:0]} : sh;
    endfunction
endpackage

// File: rtl/mwb_dmem.sv
// mwb_dmem: DEPTH x 32 data memory, byte-enable synchronous write, synchronous read.
module mwb_dmem #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    // Power-up image only; reset never touches the array.
    logic [31:0] mem [DEPTH] = '{0: 32'd12, 8: 32'd22, default: 32'd0};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_wb_unit.sv
// mem_wb_unit: memory + writeback stage with byte-lane loads/stores and access counters.
// Define MWB_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module mem_wb_unit import mwb_pkg::*; #(
    parameter int MEM_DEPTH = 128,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      EX_MWB_IR,
    input  logic [31:0]      EX_MWB_ALU_Out,
    input  logic [31:0]      B_reg,
    input  logic             EX_MWB_stall,
    output logic             writeflag,
    output logic [4:0]       dest_addr,
    output logic [31:0]      MWB_Out,
    output logic             misalign_err,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [4:0]       op, rd;
    logic [2:0]       f3;
    logic [1:0]       addr_lo, lane;
    logic             is_alu, is_ld, is_st, is_half, is_word, trap, go;
    logic [3:0]       be;
    logic [31:0]      wdata, rdata;
    logic             wf_d, wf_q, sel_ld_d, sel_ld_q, err_d, err_q;
    logic [4:0]       dest_d, dest_q;
    logic [31:0]      alu_d, alu_q;
    logic [2:0]       f3_d, f3_q;
    logic [1:0]       lane_d, lane_q;
    logic [CNT_W-1:0] ld_cnt_d, ld_cnt_q, st_cnt_d, st_cnt_q;
    logic             unused_bits;

    assign op          = EX_MWB_IR[6:2];
    assign rd          = EX_MWB_IR[11:7];
    assign f3          = EX_MWB_IR[14:12];
    assign addr_lo     = EX_MWB_ALU_Out[1:0];
    assign unused_bits = ^{EX_MWB_IR[31:15], EX_MWB_IR[1:0], EX_MWB_ALU_Out[31:AW+2]};

    assign is_alu  = op == OP_R || op == OP_I;
    assign is_ld   = op == OP_LOAD && (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    assign is_st   = op == OP_STORE && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
    assign is_half = f3[1:0] == 2'b01;
    assign is_word = f3[1:0] == 2'b10;

`ifdef MWB_MISALIGN_TRAP_EN
    assign trap = (is_ld || is_st) && ((is_half && addr_lo[0]) || (is_word && addr_lo != 2'b00));
    assign lane = addr_lo;
`else
    assign trap = 1'b0;
    assign lane = is_word ? 2'b00 : is_half ? {addr_lo[1], 1'b0} : addr_lo;
`endif

    assign go = !EX_MWB_stall && !trap;

    always_comb begin
        be       = !(is_st && go) ? 4'b0000 : is_word ? 4'b1111 :
                   is_half ? 4'b0011 << lane : 4'b0001 << lane;
        wdata    = is_word ? B_reg : is_half ? {2{B_reg[15:0]}} : {4{B_reg[7:0]}};
        wf_d     = go && (is_alu || is_ld) && rd != 5'd0;
        sel_ld_d = go && is_ld;
        err_d    = !EX_MWB_stall && trap;
        dest_d   = wf_d ? rd : 5'd0;
        alu_d    = wf_d && is_alu ? EX_MWB_ALU_Out : 32'd0;
        f3_d     = f3;
        lane_d   = lane;
        ld_cnt_d = ld_cnt_q + {{(CNT_W-1){1'b0}}, go && is_ld};
        st_cnt_d = st_cnt_q + {{(CNT_W-1){1'b0}}, go && is_st};
    end

    // Write enables are masked by rst so an access sampled during reset never lands.
    mwb_dmem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_dmem (
        .clk   (clk),
        .addr  (EX_MWB_ALU_Out[AW+1:2]),
        .be    (be & {4{~rst}}),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wf_q     <= 1'b0;
            sel_ld_q <= 1'b0;
            err_q    <= 1'b0;
            dest_q   <= 5'd0;
            alu_q    <= 32'd0;
            f3_q     <= 3'd0;
            lane_q   <= 2'd0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            wf_q     <= wf_d;
            sel_ld_q <= sel_ld_d;
            err_q    <= err_d;
            dest_q   <= dest_d;
            alu_q    <= alu_d;
            f3_q     <= f3_d;
            lane_q   <= lane_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    // Load data is extended from the synchronously-read word using the lane/funct3 captured alongside it.
    assign writeflag    = wf_q;
    assign dest_addr    = dest_q;
    assign MWB_Out      = !wf_q ? 32'd0 : sel_ld_q ? load_extend(rdata, lane_q, f3_q) : alu_q;
    assign misalign_err = err_q;
    assign ld_cnt       = ld_cnt_q;
    assign st_cnt       = st_cnt_q;
endmodule

// File: tb/tb_mem_wb_unit.sv
// tb_mem_wb_unit: scoreboard bench for mem_wb_unit; expectations come from a behavioural memory model.
module tb_mem_wb_unit;
    localparam int DEPTH = 128;
    localparam int CW    = 16;
`ifdef MWB_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [4:0] OPR = 5'b01100, OPI = 5'b00100, OPL = 5'b00000, OPS = 5'b01000;

    typedef struct packed {
        logic          wf;
        logic [4:0]    rd;
        logic [31:0]   data;
        logic          err;
        logic [CW-1:0] ld;
        logic [CW-1:0] st;
    } obs_t;

    logic clk = 0, rst = 1, stall = 1;
    logic [31:0] ir = 0, alu = 0, b = 0;
    logic writeflag, misalign_err;
    logic [4:0] dest_addr;
    logic [31:0] MWB_Out;
    logic [CW-1:0] ld_cnt, st_cnt;

    obs_t exp_q[$], got_q[$];
    logic [31:0] m_mem [DEPTH];
    logic [CW-1:0] m_ld = 0, m_st = 0;
    int n_cmp = 0, n_bad = 0;

    mem_wb_unit #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .EX_MWB_IR(ir), .EX_MWB_ALU_Out(alu), .B_reg(b),
        .EX_MWB_stall(stall), .writeflag(writeflag), .dest_addr(dest_addr),
        .MWB_Out(MWB_Out), .misalign_err(misalign_err), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(logic [4:0] op, logic [2:0] f3, logic [4:0] rd);
        return {17'd0, f3, rd, op, 2'b11};
    endfunction

    function automatic obs_t sample();
        return {writeflag, dest_addr, MWB_Out, misalign_err, ld_cnt, st_cnt};
    endfunction

    function automatic string show(obs_t o);
        return $sformatf("wf=%0b rd=%0d out=%h err=%0b ld=%0d st=%0d", o.wf, o.rd, o.data, o.err, o.ld, o.st);
    endfunction

    // Reference model: byte-addressed memory with size/offset semantics for one sampled slot.
    function automatic obs_t model(logic [31:0] i, logic [31:0] a, logic [31:0] d, logic s);
        obs_t e = '0;
        logic [4:0] op = i[6:2];
        logic [4:0] rd = i[11:7];
        logic [2:0] f3 = i[14:12];
        int w = int'((a >> 2) % DEPTH);
        int off = int'(a[1:0]);
        int sz = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
        bit ld_ok = op == OPL && sz != 0;
        bit st_ok = op == OPS && sz != 0 && f3 < 3;
        bit mis = sz != 0 && (off % sz) != 0;
        logic [31:0] v;
        if (!s) begin
            if ((ld_ok || st_ok) && mis && TRAP) e.err = 1;
            else begin
                if (sz != 0) off = off - off % sz;
                if (st_ok) begin
                    for (int k = 0; k < sz; k++) m_mem[w][8*(off+k) +: 8] = d[8*k +: 8];
                    m_st++;
                end else if (ld_ok) begin
                    v = m_mem[w] >> (8 * off);
                    if (sz == 1) v = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
                    if (sz == 2) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                    m_ld++;
                    if (rd != 0) begin e.wf = 1; e.rd = rd; e.data = v; end
                end else if ((op == OPR || op == OPI) && rd != 0) begin
                    e.wf = 1; e.rd = rd; e.data = a;
                end
            end
        end
        e.ld = m_ld;
        e.st = m_st;
        return e;
    endfunction

    task automatic step(logic [31:0] i, logic [31:0] a, logic [31:0] d, logic s = 0);
        @(negedge clk);
        ir = i; alu = a; b = d; stall = s;
        exp_q.push_back(model(i, a, d, s));
        @(posedge clk);
        #1 got_q.push_back(sample());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; stall = 1;
        @(negedge clk);
        rst = 0; m_ld = 0; m_st = 0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        foreach (m_mem[i]) m_mem[i] = 0;
        m_mem[0] = 12; m_mem[8] = 22;
        rst = 1; ir = ins(OPS, 3'd2, 0); alu = 0; b = 32'hFFFF_FFFF; stall = 0;
        repeat (3) @(posedge clk);
        #1 g = sample();
        n_cmp++;
        if (g !== '0) begin n_bad++; $display("FAIL reset_outputs: got %s exp all zero", show(g)); end
        @(negedge clk);
        rst = 0; stall = 1;
        step(ins(OPL, 3'd2, 1), 32'h0, 0);
        step(ins(OPL, 3'd2, 2), 32'h20, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL init_image[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    task automatic test_lanes();
        obs_t e, g;
        step(ins(OPS, 3'd2, 0), 32'h10, 32'hDEAD_BEEF);
        step(ins(OPL, 3'd2, 5), 32'h10, 0);
        step(ins(OPS, 3'd0, 0), 32'h13, 32'h0000_0080);
        step(ins(OPL, 3'd0, 6), 32'h13, 0);
        step(ins(OPL, 3'd4, 7), 32'h13, 0);
        step(ins(OPL, 3'd2, 8), 32'h10, 0);
        step(ins(OPS, 3'd1, 0), 32'h1A, 32'h1234_8001);
        step(ins(OPL, 3'd1, 9), 32'h1A, 0);
        step(ins(OPL, 3'd5, 10), 32'h1A, 0);
        step(ins(OPL, 3'd2, 11), 32'h18, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL lanes[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    task automatic test_misalign();
        obs_t e, g;
        step(ins(OPL, 3'd1, 9), 32'h11, 0);
        step(ins(OPS, 3'd2, 0), 32'h30, 32'hA5A5_5A5A);
        step(ins(OPL, 3'd5, 12), 32'h33, 0);
        step(ins(OPL, 3'd2, 13), 32'h32, 0);
        step(ins(OPS, 3'd1, 0), 32'h31, 32'h0000_7777);
        step(ins(OPS, 3'd2, 0), 32'h33, 32'h0000_0001, 1);
        step(ins(OPS, 3'd2, 0), 32'h33, 32'h0000_0001);
        step(ins(OPL, 3'd2, 14), 32'h30, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL misalign[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    task automatic test_wrap_and_x0();
        obs_t e, g;
        step(ins(OPS, 3'd2, 0), 32'(4 * DEPTH + 4), 32'hCAFE_F00D);
        step(ins(OPL, 3'd2, 10), 32'h4, 0);
        step(ins(OPR, 3'd0, 0), 32'h7, 0);
        step(ins(OPI, 3'd0, 9), 32'h1234, 0);
        step(ins(OPS, 3'd2, 0), 32'h10, 32'h1234_5678, 1);
        step(ins(OPL, 3'd2, 0), 32'h10, 0);
        step(ins(OPS, 3'd4, 0), 32'h10, 32'h5555_5555);
        step(ins(OPL, 3'd3, 4), 32'h10, 0);
        step(ins(5'b11000, 3'd0, 3), 32'h99, 0);
        step(ins(OPL, 3'd2, 5), 32'h10, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL wrap_x0[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        logic [4:0] ops [9] = '{OPS, OPS, OPS, OPL, OPL, OPL, OPL, OPL, OPR};
        logic [2:0] f3s [9] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0};
        for (int n = 0; n < 60; n++) begin
            int j = int'($urandom_range(0, 8));
            step(ins(ops[j], f3s[j], 5'($urandom_range(0, 31))), 32'($urandom_range(0, 63)),
                 $urandom, $urandom_range(0, 9) == 0);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL back_to_back[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    task automatic test_cnt_wrap();
        obs_t e, g;
        do_reset();
        for (int n = 0; n < (1 << CW); n++) begin
            step(ins(OPL, 3'd2, 1), 32'h20, 0);
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL cnt_wrap[%0d]: got %s exp %s", n, show(g), show(e)); end
        end
        n_cmp++;
        if (ld_cnt !== '0) begin n_bad++; $display("FAIL cnt_wrap_zero: got ld_cnt=%0d exp 0", ld_cnt); end
    endtask

    task automatic test_async_reset();
        obs_t e, g;
        step(ins(OPS, 3'd2, 0), 32'h40, 32'h0BAD_F00D);
        step(ins(OPL, 3'd2, 3), 32'h40, 0);
        #2 rst = 1;
        #1 g = sample();
        n_cmp++;
        if (g !== '0) begin n_bad++; $display("FAIL async_reset: got %s exp all zero", show(g)); end
        ir = ins(OPS, 3'd2, 0); alu = 32'h20; b = 32'h55; stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0; stall = 1; m_ld = 0; m_st = 0;
        step(ins(OPL, 3'd2, 4), 32'h20, 0);
        step(ins(OPL, 3'd2, 4), 32'h40, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL async_reset_seq[%0d]: got %s exp %s", k, show(g), show(e)); end
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_misalign();
        test_wrap_and_x0();
        test_back_to_back();
        test_async_reset();
        test_cnt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
